// File: rtl/wb_trace_if.sv
// Bus bundle for the writeback trace buffer.
// It carries the datapath result strobe on the input side and the
// valid/ready drain port on the output side.
//
// Output handshake: a head entry transfers on every rising clk edge where
// out_valid && out_ready. While out_valid=1 and out_ready=0, out_data holds
// steady. out_ready has no effect while out_valid=0. out_valid never depends
// combinationally on out_ready. The input strobe has no backpressure, so an
// entry that cannot be stored is dropped and counted.
interface wb_trace_if #(
    parameter int DW = 32
);
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;

    // Environment side: the datapath drives the strobe and the sink drives ready.
    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  out_valid,
        input  out_data
    );

    // Trace buffer side.
    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/wb_trace_buffer.sv
// Writeback trace buffer.
// Captures datapath result values on a strobe. When ONCHANGE is set, it keeps
// only values that differ from the last candidate. Captured values are held in
// a show-ahead FIFO that drains through a valid/ready port. The block also
// reports occupancy, a sticky overflow flag and a saturating drop counter.
module wb_trace_buffer #(
    parameter int DW       = 32,
    parameter int DEPTH    = 16,
    parameter int ONCHANGE = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    wb_trace_if.slave                bus,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     overflow,
    output logic [15:0]              drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_next;
    logic [DW-1:0] hist_data;
    logic          hist_valid;
    logic          pop;
    logic          cand;
    logic          push;
    logic          drop;

    assign bus.out_valid = (count != '0);
    assign full          = (count == CW'(DEPTH));
    assign rd_next       = rd_ptr + 1'b1;

    // A strobe in a clr cycle is discarded outright, so clr also gates candidacy.
    // pop is not gated here. The register block gives clr priority over pop.
    assign pop  = bus.out_valid && bus.out_ready;
    assign cand = bus.in_valid && !clr &&
                  ((ONCHANGE == 0) || !hist_valid || (bus.in_data != hist_data));
    assign push = cand && (!full || pop);
    assign drop = cand && full && !pop;

    // Storage array. It has no reset because only entries below count are ever visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.in_data;
        end
    end

    // Pointers, occupancy, history, flags and the registered head entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            hist_data    <= '0;
            hist_valid   <= 1'b0;
            overflow     <= 1'b0;
            drop_cnt     <= '0;
            bus.out_data <= '0;
        end else if (clr) begin
            // Flush the buffer. out_data keeps its last value.
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            hist_valid <= 1'b0;
            overflow   <= 1'b0;
            drop_cnt   <= '0;
        end else begin
            if (cand) begin
                hist_data  <= bus.in_data;
                hist_valid <= 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_next;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 16'hFFFF) begin
                    drop_cnt <= drop_cnt + 1'b1;
                end
            end
            // Show-ahead head. The entry after the popped one is already in the
            // array unless only one entry remains. In that case the head comes
            // from a simultaneous push, if there is one. When the buffer is full,
            // a simultaneous write lands on rd_ptr and never on rd_next, so the
            // array read below is safe.
            if (pop) begin
                if (count > CW'(1)) begin
                    bus.out_data <= mem[rd_next];
                end else if (push) begin
                    bus.out_data <= bus.in_data;
                end
            end else if (push && (count == '0)) begin
                bus.out_data <= bus.in_data;
            end
        end
    end
endmodule

// File: tb/tb_wb_trace_buffer.sv
// Self-checking bench for wb_trace_buffer.
// Instance dut (ONCHANGE=1) is tracked by a reference model with an expected
// queue. Instance dut_b (ONCHANGE=0) shares the same stimulus and is checked
// against directed constants.
module tb_wb_trace_buffer;
    localparam int DW    = 32;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clr = 1'b0;
    logic          in_valid = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic          out_ready = 1'b0;

    logic [4:0]  count, count_b;
    logic        full, full_b;
    logic        overflow, overflow_b;
    logic [15:0] drop_cnt, drop_cnt_b;

    wb_trace_if #(.DW(DW)) bus_a ();
    wb_trace_if #(.DW(DW)) bus_b ();

    assign bus_a.in_valid  = in_valid;
    assign bus_a.in_data   = in_data;
    assign bus_a.out_ready = out_ready;
    assign bus_b.in_valid  = in_valid;
    assign bus_b.in_data   = in_data;
    assign bus_b.out_ready = out_ready;

    wb_trace_buffer #(.DW(DW), .DEPTH(DEPTH), .ONCHANGE(1)) dut (
        .clk(clk), .rst(rst), .clr(clr), .bus(bus_a),
        .count(count), .full(full), .overflow(overflow), .drop_cnt(drop_cnt)
    );

    wb_trace_buffer #(.DW(DW), .DEPTH(DEPTH), .ONCHANGE(0)) dut_b (
        .clk(clk), .rst(rst), .clr(clr), .bus(bus_b),
        .count(count_b), .full(full_b), .overflow(overflow_b), .drop_cnt(drop_cnt_b)
    );

    // Clock generation.
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Scoreboard state for dut (ONCHANGE=1).
    logic [DW-1:0] exp_q[$];
    int            m_count = 0;
    logic          m_hv = 1'b0;
    logic [DW-1:0] m_hist = '0;
    logic          m_ovf = 1'b0;
    logic [15:0]   m_drop = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_count = 0;
        m_hv    = 1'b0;
        m_ovf   = 1'b0;
        m_drop  = '0;
        exp_q.delete();
    endtask

    // Drive one cycle, starting #1 after a rising edge.
    // Pops are scored before the edge. Status is scored #1 after it.
    task automatic step(input logic iv, input logic [DW-1:0] d, input logic rdy, input logic cl);
        logic pop, cand, push;
        in_valid  = iv;
        in_data   = d;
        out_ready = rdy;
        clr       = cl;
        #1;
        check("out_valid", bus_a.out_valid, (m_count != 0));
        if (cl) begin
            model_reset();
        end else begin
            pop  = (m_count != 0) && rdy;
            cand = iv && (!m_hv || d != m_hist);
            if (pop) begin
                if (exp_q.size() == 0) begin
                    check("sb_underflow", 1, 0);
                end else begin
                    check("out_data", bus_a.out_data, exp_q.pop_front());
                end
            end
            if (cand) begin
                m_hv   = 1'b1;
                m_hist = d;
            end
            push = cand && (m_count < DEPTH || pop);
            if (push) exp_q.push_back(d);
            if (cand && !push) begin
                m_ovf = 1'b1;
                if (m_drop != 16'hFFFF) m_drop++;
            end
            m_count = m_count + int'(push) - int'(pop);
        end
        @(posedge clk);
        #1;
        check("count", count, m_count);
        check("full", full, (m_count == DEPTH));
        check("overflow", overflow, m_ovf);
        check("drop_cnt", drop_cnt, m_drop);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        clr       = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (m_count != 0 && guard < 64) begin
            step(1'b0, '0, 1'b1, 1'b0);
            guard++;
        end
        check("drain_done", m_count, 0);
    endtask

    logic [DW-1:0] b_exp [3] = '{32'd5, 32'd5, 32'd7};

    initial begin
        // Reset.
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_out_valid", bus_a.out_valid, 0);
        check("rst_out_data", bus_a.out_data, 0);
        check("rst_count", count, 0);
        check("rst_full", full, 0);
        check("rst_overflow", overflow, 0);
        check("rst_drop_cnt", drop_cnt, 0);

        // 5,5,7 with out_ready low.
        step(1'b1, 32'd5, 1'b0, 1'b0);
        check("first_valid", bus_a.out_valid, 1);
        step(1'b1, 32'd5, 1'b0, 1'b0);
        step(1'b1, 32'd7, 1'b0, 1'b0);
        check("onchange_count", count, 2);
        check("onchange_head", bus_a.out_data, 5);
        check("every_count", count_b, 3);

        // Drain both. dut_b must yield 5,5,7.
        for (int k = 0; k < 3; k++) begin
            check("every_drain", bus_b.out_data, b_exp[k]);
            check("every_valid", bus_b.out_valid, 1);
            step(1'b0, '0, 1'b1, 1'b0);
        end
        check("every_empty_valid", bus_b.out_valid, 0);
        check("every_empty_count", count_b, 0);
        drain();

        // Fill with 1..16, then overflow with 17 and 18.
        for (int v = 1; v <= 16; v++) step(1'b1, DW'(v), 1'b0, 1'b0);
        check("fill_full", full, 1);
        step(1'b1, 32'd17, 1'b0, 1'b0);
        step(1'b1, 32'd18, 1'b0, 1'b0);
        check("ovf_flag", overflow, 1);
        check("ovf_drops", drop_cnt, 2);

        // Push while full, with a pop in the same cycle.
        step(1'b1, 32'd99, 1'b1, 1'b0);
        check("pushpop_count", count, 16);
        check("pushpop_drops", drop_cnt, 2);
        drain();

        // Pointer wrap with random interleaved pops.
        for (int i = 0; i < 20; i++) step(1'b1, DW'(100 + i), 1'($urandom_range(0, 1)), 1'b0);
        for (int i = 0; i < 12; i++) step(1'($urandom_range(0, 1)), DW'(200 + i), 1'b1, 1'b0);
        drain();

        // Apply clr on the same cycle as a strobe of 42.
        step(1'b1, 32'd40, 1'b0, 1'b0);
        step(1'b1, 32'd42, 1'b0, 1'b0);
        for (int v = 0; v < 16; v++) step(1'b1, DW'(300 + v), 1'b0, 1'b0);
        check("pre_clr_ovf", overflow, 1);
        step(1'b1, 32'd42, 1'b0, 1'b1);
        check("clr_count", count, 0);
        check("clr_valid", bus_a.out_valid, 0);
        check("clr_overflow", overflow, 0);
        check("clr_drops", drop_cnt, 0);
        step(1'b1, 32'd42, 1'b0, 1'b0);
        check("post_clr_42", count, 1);
        step(1'b1, 32'd43, 1'b0, 1'b0);

        // Pulse async reset between clock edges.
        #2;
        rst = 1'b1;
        #1;
        check("arst_count", count, 0);
        check("arst_valid", bus_a.out_valid, 0);
        check("arst_data", bus_a.out_data, 0);
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        step(1'b1, 32'd43, 1'b0, 1'b0);
        check("post_rst_first", count, 1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/wb_trace_buffer.md
Name: wb_trace_buffer

Overview:
- Downstream consumer of the datapath's 32-bit writeback/result output.
- Captures result values on a strobe, optionally only when the value changes, and buffers them in a show-ahead FIFO.
- Drains through a valid/ready port to a trace sink (UART bridge, bench monitor).
- Reports occupancy, a sticky overflow flag and a saturating drop counter.

Parameters:
DW, 32, data width of captured result
DEPTH, 16, FIFO entries; power of two, minimum 2
ONCHANGE, 1, 1 = record only values differing from last candidate; 0 = record every strobe

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-high reset
clr  input  1  synchronous flush: empties FIFO, clears flags and history
in_valid  input  1  result strobe from datapath writeback
in_data  input  DW  result value
out_valid  output  1  head entry available
out_ready  input  1  sink accepts head entry this cycle
out_data  output  DW  head entry; stable while out_valid=1 and out_ready=0
count  output  log2(DEPTH)+1  current occupancy, 0..DEPTH
full  output  1  count==DEPTH
overflow  output  1  sticky: a candidate was dropped
drop_cnt  output  16  dropped candidates, saturating at 0xFFFF

Behaviour:
- Interface: one clock (clk); rst asynchronous, active-high.
- Reset (rst=1, asynchronous): out_valid=0, out_data=0, count=0, full=0, overflow=0, drop_cnt=0.
  - Read and write pointers = 0.
  - History register invalid.
- Candidate: in_valid=1, and either ONCHANGE=0, or history invalid, or in_data != history value.
- Every candidate loads history with in_data and sets history valid, whether it is stored or dropped.
- Non-candidate strobes (equal value, ONCHANGE=1) are ignored silently: no drop, no count change.
- Pop: out_valid && out_ready; advances the read pointer.
- Push: candidate && (!full || pop). A push when full is legal only when a pop occurs in the same cycle.
- Drop: candidate && full && !pop.
  - overflow set to 1 until clr or rst.
  - drop_cnt increments; holds at 0xFFFF.
- Count update:
  - push only: +1
  - pop only: -1
  - both: unchanged
- Latency: a value pushed in cycle N appears on out_data with out_valid=1 from cycle N+1. No same-cycle bypass when empty.
- out_data is the registered head entry (show-ahead). When the FIFO goes empty, out_data holds its last value with out_valid=0.
- Pointers are log2(DEPTH) bits and wrap from DEPTH-1 to 0 naturally.
  - full/empty derive from count, not pointer equality.
- clr=1 (synchronous) has priority over in_valid and out_ready in the same cycle.
  - Next state: count=0, out_valid=0, overflow=0, drop_cnt=0, history invalid.
  - Pointers = 0; out_data holds its value.
  - Strobe in a clr cycle is discarded and does not load history.
- rst asserted mid-transfer: immediate return to reset values; FIFO contents are lost.
  - First candidate after release is always recorded (history invalid).
- out_ready while out_valid=0: no effect.
- No X on outputs after reset. Storage array needs no reset; only entries below count are observable.

Test Plan:
- Reset, then strobe in_data=5,5,7 on consecutive cycles (ONCHANGE=1, out_ready=0) -> count=2; out_valid rises the cycle after the first strobe; out_data=5.
- Same strobes with ONCHANGE=0 -> count=3; then drain with out_ready=1 -> out_data 5,5,7 on successive cycles; out_valid=0 after the third pop; count=0.
- Fill with 16 distinct values 1..16, then strobe 17,18 with out_ready=0 -> full=1, overflow=1, drop_cnt=2; drained order is 1..16.
- With full=1, strobe 99 and out_ready=1 in the same cycle -> push accepted, count stays 16, drop_cnt unchanged; last drained value is 99.
- Push 20 values through with interleaved pops (pointer wrap past 15) -> output order matches input order exactly; count never exceeds 16.
- Mid-stream clr coincident with in_valid (value 42) -> next cycle count=0, out_valid=0, overflow=0, drop_cnt=0. Subsequent strobe 42 is recorded (history cleared). Async rst pulse between clock edges clears outputs immediately.
